// File: rtl/oam_line_scanner.sv
`default_nettype none
// ============================================================================
// Module  : oam_line_scanner
// Brief   : Mode-2 sprite search. Walks the OAM Y/X table once per scanline
//           and keeps up to MAX_PER_LINE covering sprites in a line buffer.
//           Define OAM_LINE_SCANNER_SORT_EN to keep the buffer sorted by X.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module oam_line_scanner #(
    parameter int NUM_SPRITES  = 40,
    parameter int MAX_PER_LINE = 10,
    parameter int IDX_W        = $clog2(NUM_SPRITES),
    parameter int CNT_W        = $clog2(MAX_PER_LINE + 1),
    parameter int TALL_HEIGHT  = 16,
    parameter int Y_OFFSET     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       ly,
    input  logic             sprite_size,
    output logic [IDX_W-1:0] oam_addr,
    output logic             oam_rd,
    input  logic [7:0]       oam_y,
    input  logic [7:0]       oam_x,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic [CNT_W-1:0] rd_sel,
    output logic [IDX_W-1:0] rd_index,
    output logic [7:0]       rd_x
);

    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_scan  = 2'd1;
    localparam logic [1:0]       c_st_drain = 2'd2;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0] c_max_cnt  = CNT_W'(MAX_PER_LINE);
    localparam logic [8:0]       c_y_off    = 9'(Y_OFFSET);
    localparam logic [8:0]       c_h_tall   = 9'(TALL_HEIGHT);
    localparam logic [8:0]       c_h_short  = 9'd8;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             w_rd;
    logic             w_finish;

    logic [IDX_W-1:0] r_addr;
    logic             r_rd_q;
    logic [IDX_W-1:0] r_idx_q;
    logic [7:0]       r_ly;
    logic             r_tall;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_done;

    logic [IDX_W-1:0] r_slot_idx [MAX_PER_LINE];
    logic [7:0]       r_slot_x   [MAX_PER_LINE];
    logic [IDX_W-1:0] w_nxt_idx  [MAX_PER_LINE];
    logic [7:0]       w_nxt_x    [MAX_PER_LINE];

    logic [8:0]       w_row;
    logic [8:0]       w_top;
    logic [8:0]       w_height;
    logic             w_hit;
    logic             w_eval;
    logic             w_store;
    logic             w_drop;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd         = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_next_state = c_st_idle;
            end
            c_st_scan: begin
                w_rd = 1'b1;
                if (r_addr == c_last_idx) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                w_finish     = ~start;
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
        // A start in any state (re)launches the scan from index 0
        if (start) begin
            w_next_state = c_st_scan;
        end
    end

    // ------------------------------------------------------------------------
    // Hit test on the entry returned for the previous cycle's read
    // ------------------------------------------------------------------------
    always_comb begin
        w_row    = {1'b0, r_ly} + c_y_off;
        w_top    = {1'b0, oam_y};
        w_height = r_tall ? c_h_tall : c_h_short;
        w_hit    = (oam_y != 8'd0) && (w_row >= w_top) && (w_row < (w_top + w_height));
        w_eval   = r_rd_q & ~start;
        w_store  = w_eval & w_hit & (r_count < c_max_cnt);
        w_drop   = w_eval & w_hit & (r_count == c_max_cnt);
    end

    // ------------------------------------------------------------------------
    // Line buffer next-state
    // ------------------------------------------------------------------------
`ifdef OAM_LINE_SCANNER_SORT_EN
    logic [MAX_PER_LINE-1:0] w_gt;

    always_comb begin
        w_nxt_idx = r_slot_idx;
        w_nxt_x   = r_slot_x;
        w_gt      = '0;
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            w_gt[i] = (CNT_W'(i) < r_count) && (r_slot_x[i] > oam_x);
        end
        // Entries with a strictly larger X move up, so equal X keeps OAM order
        if (w_store) begin
            if (w_gt[0] || (r_count == '0)) begin
                w_nxt_idx[0] = r_idx_q;
                w_nxt_x[0]   = oam_x;
            end
            for (int i = 1; i < MAX_PER_LINE; i++) begin
                if (CNT_W'(i) <= r_count) begin
                    if (w_gt[i-1]) begin
                        w_nxt_idx[i] = r_slot_idx[i-1];
                        w_nxt_x[i]   = r_slot_x[i-1];
                    end else if ((CNT_W'(i) == r_count) || w_gt[i]) begin
                        w_nxt_idx[i] = r_idx_q;
                        w_nxt_x[i]   = oam_x;
                    end
                end
            end
        end
    end
`else
    always_comb begin
        w_nxt_idx = r_slot_idx;
        w_nxt_x   = r_slot_x;
        if (w_store) begin
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                if (CNT_W'(i) == r_count) begin
                    w_nxt_idx[i] = r_idx_q;
                    w_nxt_x[i]   = oam_x;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_rd_q     <= 1'b0;
            r_idx_q    <= '0;
            r_ly       <= 8'd0;
            r_tall     <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                r_slot_idx[i] <= '0;
                r_slot_x[i]   <= 8'd0;
            end
        end else begin
            r_done  <= w_finish;
            r_rd_q  <= w_rd & ~start;
            r_idx_q <= r_addr;
            r_addr  <= (w_rd && !start && (r_addr != c_last_idx)) ? (r_addr + IDX_W'(1)) : '0;
            if (start) begin
                r_ly       <= ly;
                r_tall     <= sprite_size;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_store) begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
            r_slot_idx <= w_nxt_idx;
            r_slot_x   <= w_nxt_x;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs and combinational slot read
    // ------------------------------------------------------------------------
    assign oam_rd   = w_rd;
    assign oam_addr = r_addr;
    assign busy     = (r_state != c_st_idle) | r_done;
    assign done     = r_done;
    assign count    = r_count;
    assign overflow = r_overflow;

    always_comb begin
        rd_index = '0;
        rd_x     = 8'd0;
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (rd_sel == CNT_W'(i)) begin
                rd_index = r_slot_idx[i];
                rd_x     = r_slot_x[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oam_line_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_oam_line_scanner
// Brief   : Scoreboard bench for oam_line_scanner with an OAM memory model and
//           a row-coverage reference model of the sprite search.
// Revision: 1.0 - initial release
// ============================================================================
module tb_oam_line_scanner;

    localparam int NUM   = 40;
    localparam int MAX   = 10;
    localparam int IDX_W = 6;
    localparam int CNT_W = 4;
    localparam int LAT   = NUM + 1;

    logic             clk         = 1'b0;
    logic             reset_n     = 1'b0;
    logic             start       = 1'b0;
    logic [7:0]       ly          = 8'd0;
    logic             sprite_size = 1'b0;
    logic [IDX_W-1:0] oam_addr;
    logic             oam_rd;
    logic [7:0]       oam_y       = 8'd0;
    logic [7:0]       oam_x       = 8'd0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [CNT_W-1:0] rd_sel      = '0;
    logic [IDX_W-1:0] rd_index;
    logic [7:0]       rd_x;

    oam_line_scanner dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .ly          (ly),
        .sprite_size (sprite_size),
        .oam_addr    (oam_addr),
        .oam_rd      (oam_rd),
        .oam_y       (oam_y),
        .oam_x       (oam_x),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .overflow    (overflow),
        .rd_sel      (rd_sel),
        .rd_index    (rd_index),
        .rd_x        (rd_x)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // OAM table: data for a read appears on the cycle after the strobe
    int mem_y [NUM];
    int mem_x [NUM];
    always @(posedge clk) begin
        if (oam_rd) begin
            oam_y <= 8'(mem_y[oam_addr]);
            oam_x <= 8'(mem_x[oam_addr]);
        end
    end

    typedef struct {
        int cnt;
        int ovf;
        int idx [MAX];
        int x   [MAX];
        int start_cyc;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Screen row of a sprite = Y - 16; it covers rows [top, top+height)
    function automatic exp_t model(input int l, input bit tall, input int scyc);
        exp_t e;
        int   h;
        int   top;
        int   ti;
        int   tx;
        e.cnt       = 0;
        e.ovf       = 0;
        e.start_cyc = scyc;
        for (int i = 0; i < MAX; i++) begin
            e.idx[i] = 0;
            e.x[i]   = 0;
        end
        h = tall ? 16 : 8;
        for (int i = 0; i < NUM; i++) begin
            top = mem_y[i] - 16;
            if (mem_y[i] != 0 && l >= top && l < top + h) begin
                if (e.cnt < MAX) begin
                    e.idx[e.cnt] = i;
                    e.x[e.cnt]   = mem_x[i];
                    e.cnt++;
                end else begin
                    e.ovf = 1;
                end
            end
        end
`ifdef OAM_LINE_SCANNER_SORT_EN
        for (int a = 0; a < e.cnt; a++) begin
            for (int b = 0; b + 1 < e.cnt - a; b++) begin
                if (e.x[b] * 256 + e.idx[b] > e.x[b+1] * 256 + e.idx[b+1]) begin
                    ti = e.idx[b]; e.idx[b] = e.idx[b+1]; e.idx[b+1] = ti;
                    tx = e.x[b];   e.x[b]   = e.x[b+1];   e.x[b+1]   = tx;
                end
            end
        end
`else
        ti = 0;
        tx = 0;
`endif
        return e;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < NUM; i++) begin
            mem_y[i] = 0;
            mem_x[i] = $urandom_range(0, 255);
        end
    endtask

    task automatic rand_mem(input int l);
        int v;
        for (int i = 0; i < NUM; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                mem_y[i] = 0;
            end else begin
                v = l + 16 - 18 + $urandom_range(0, 26);
                if (v < 0)   v = 0;
                if (v > 255) v = 255;
                mem_y[i] = v;
            end
            mem_x[i] = ($urandom_range(0, 3) == 0) ? 50 : $urandom_range(0, 255);
        end
    endtask

    task automatic start_scan(input int l, input bit tall);
        @(negedge clk);
        ly          = 8'(l);
        sprite_size = tall;
        start       = 1'b1;
        sb.push_back(model(l, tall, cyc + 1));
        @(negedge clk);
        start       = 1'b0;
        chk("busy_after_start", busy, 1);
        // Disturb the live inputs; the scan must use the latched copies
        ly          = 8'($urandom);
        sprite_size = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && sb.size() != 0; k++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk("scan_timeout_pending", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_width", done, 0);
    endtask

    // Monitor: pops one expectation per done pulse and reads the line buffer
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.start_cyc, LAT);
                    chk("count", count, e.cnt);
                    chk("overflow", overflow, e.ovf);
                    chk("busy_at_done", busy, 1);
                    for (int i = 0; i < e.cnt; i++) begin
                        rd_sel = CNT_W'(i);
                        #0.05;
                        chk($sformatf("slot%0d_index", i), rd_index, e.idx[i]);
                        chk($sformatf("slot%0d_x", i), rd_x, e.x[i]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_oam_rd", oam_rd, 0);
        chk("rst_oam_addr", oam_addr, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two hits on line 0; Y=8 sits entirely above the screen
        clear_mem();
        mem_y[3] = 16;
        mem_y[7] = 9;
        mem_y[8] = 8;
        start_scan(0, 1'b0);
        wait_idle();

        // Tall sprite covers line 10, short one does not
        clear_mem();
        mem_y[5] = 11;
        start_scan(10, 1'b1);
        wait_idle();
        start_scan(10, 1'b0);
        wait_idle();

        // Overflow, then a clean line clears it
        for (int i = 0; i < NUM; i++) mem_y[i] = 16;
        start_scan(0, 1'b0);
        wait_idle();
        clear_mem();
        start_scan(0, 1'b0);
        wait_idle();

        // Restart mid-scan: only the second scan may complete
        rand_mem(60);
        start_scan(60, 1'b0);
        repeat (18) @(negedge clk);
        void'(sb.pop_back());
        rand_mem(61);
        start_scan(61, 1'b1);
        wait_idle();

        // Reset mid-scan
        rand_mem(30);
        start_scan(30, 1'b0);
        repeat (13) @(negedge clk);
        reset_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        chk("midrst_done", done, 0);
        chk("midrst_oam_rd", oam_rd, 0);
        chk("midrst_overflow", overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        start_scan(30, 1'b0);
        wait_idle();

        // X ordering with a tie at X=50
        clear_mem();
        mem_y[2] = 16; mem_x[2] = 50;
        mem_y[4] = 16; mem_x[4] = 20;
        mem_y[6] = 16; mem_x[6] = 50;
        mem_y[9] = 16; mem_x[9] = 8;
        start_scan(0, 1'b0);
        wait_idle();

        // Randomised lines
        for (int n = 0; n < 25; n++) begin
            int l;
            l = $urandom_range(0, 143);
            rand_mem(l);
            start_scan(l, 1'($urandom_range(0, 1)));
            wait_idle();
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
